// File: rtl/ofmap_write_collector_pkg.sv
// ofmap_write_collector_pkg: shared conv-stream state encodings, defaults and ReLU helper
package ofmap_write_collector_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TILING_SIZE = 8;
  typedef enum logic [1:0] {IDLE, ARMED, RECV, DONE} state_t;
  function automatic logic relu_keep(input logic sign, input logic en);
    return !(en && sign);
  endfunction
endpackage

// File: rtl/ofmap_addr_gen.sv
// ofmap_addr_gen: sequential ofmap write pointer with tile-start rewind
module ofmap_addr_gen #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  inc,
  input  logic                  tile_end,
  input  logic                  rewind,
  output logic [ADDR_WIDTH-1:0] wr_ptr
);
  logic [ADDR_WIDTH-1:0] tile_start;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      tile_start <= '0;
    end else if (load) begin
      wr_ptr <= base_addr;
      tile_start <= base_addr;
    end else if (rewind) begin
      wr_ptr <= tile_start;
    end else if (inc) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (tile_end) tile_start <= wr_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/ofmap_write_collector.sv
// ofmap_write_collector: collects tile bursts, applies ReLU and writes them to the ofmap SRAM
module ofmap_write_collector
  import ofmap_write_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TILING_SIZE = DEF_TILING_SIZE,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_TILES = 64,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  valid_data,
  input  logic [DATA_WIDTH-1:0] data_output,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [15:0]           tile_count,
  output logic                  burst_err,
  output logic                  done
);
  localparam int CW = TILING_SIZE > 1 ? $clog2(TILING_SIZE) : 1;
  state_t state;
  logic [CW-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic active, accept, last, short_burst;
  logic [15:0] tile_next;
  assign active = state == ARMED || state == RECV;
  assign accept = active && valid_data && !start;
  assign last = accept && word_cnt == CW'(TILING_SIZE - 1);
  assign short_burst = state == RECV && !valid_data && !start && word_cnt != '0;
  assign tile_next = tile_count == 16'hFFFF ? tile_count : tile_count + 16'd1;
  ofmap_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr_gen (
    .clk(clk),
    .rst_n(rst_n),
    .load(start),
    .base_addr(base_addr),
    .inc(accept),
    .tile_end(last),
    .rewind(short_burst),
    .wr_ptr(wr_ptr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word_cnt <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      tile_count <= '0;
      burst_err <= 1'b0;
      done <= 1'b0;
    end else begin
      mem_we <= accept;
      done <= 1'b0;
      if (accept) begin
        mem_addr <= wr_ptr;
        mem_wdata <= relu_keep(data_output[DATA_WIDTH-1], RELU_EN) ? data_output : '0;
      end
      if (start) begin
        state <= ARMED;
        word_cnt <= '0;
        tile_count <= '0;
        burst_err <= 1'b0;
      end else if (last) begin
        word_cnt <= '0;
        tile_count <= tile_next;
        state <= tile_next == 16'(NUM_TILES) ? DONE : RECV;
        done <= tile_next == 16'(NUM_TILES);
      end else if (accept) begin
        word_cnt <= word_cnt + 1'b1;
        state <= RECV;
      end else if (state == RECV && !valid_data) begin
        // a burst that ends on a tile boundary is not an error
        state <= ARMED;
        word_cnt <= '0;
        burst_err <= burst_err | short_burst;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ofmap_write_collector.sv
// tb_ofmap_write_collector: randomized and directed checks of two collector configs against a reference model
module tb_ofmap_write_collector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic valid_data = 1'b0;
  logic [15:0] base_addr = '0;
  logic [15:0] data_output = '0;
  logic [1:0] mem_we, burst_err, done;
  logic [1:0][15:0] mem_addr, mem_wdata, tile_count;
  int errors = 0;
  int checks = 0;
  int nt[2] = '{2, 64};
  bit relu[2] = '{1'b1, 1'b0};
  bit act[2], err[2], e_we[2], e_done[2];
  int cnt[2], ptr[2], tb[2], tiles[2], e_addr[2], e_data[2];
  always #5 clk = ~clk;
  ofmap_write_collector #(.NUM_TILES(2), .RELU_EN(1'b1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .valid_data(valid_data), .data_output(data_output),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .tile_count(tile_count[0]), .burst_err(burst_err[0]), .done(done[0])
  );
  ofmap_write_collector #(.NUM_TILES(64), .RELU_EN(1'b0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .valid_data(valid_data), .data_output(data_output),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .tile_count(tile_count[1]), .burst_err(burst_err[1]), .done(done[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act[i] = 0; err[i] = 0; e_we[i] = 0; e_done[i] = 0;
      cnt[i] = 0; ptr[i] = 0; tb[i] = 0; tiles[i] = 0;
    end
  endtask
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      e_we[i] = 0;
      e_done[i] = 0;
      if (start) begin
        act[i] = 1; err[i] = 0; cnt[i] = 0; tiles[i] = 0;
        ptr[i] = base_addr; tb[i] = base_addr;
      end else if (act[i] && valid_data) begin
        e_we[i] = 1;
        e_addr[i] = ptr[i];
        e_data[i] = (relu[i] && data_output[15]) ? 0 : int'(data_output);
        ptr[i] = (ptr[i] + 1) % 65536;
        cnt[i]++;
        if (cnt[i] == 8) begin
          cnt[i] = 0;
          if (tiles[i] < 65535) tiles[i]++;
          tb[i] = ptr[i];
          if (tiles[i] == nt[i]) begin
            act[i] = 0;
            e_done[i] = 1;
          end
        end
      end else if (act[i] && cnt[i] != 0) begin
        err[i] = 1;
        cnt[i] = 0;
        ptr[i] = tb[i];
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("u%0d we", i), 32'(mem_we[i]), 32'(e_we[i]));
      check($sformatf("u%0d tiles", i), 32'(tile_count[i]), tiles[i]);
      check($sformatf("u%0d err", i), 32'(burst_err[i]), 32'(err[i]));
      check($sformatf("u%0d done", i), 32'(done[i]), 32'(e_done[i]));
      if (e_we[i]) begin
        check($sformatf("u%0d addr", i), 32'(mem_addr[i]), e_addr[i]);
        check($sformatf("u%0d data", i), 32'(mem_wdata[i]), e_data[i]);
      end
    end
  endtask
  task automatic idle(input int n);
    valid_data = 0;
    start = 0;
    repeat (n) tick();
  endtask
  task automatic pulse_start(input logic [15:0] b);
    base_addr = b;
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic burst(input int n, input logic [15:0] first);
    for (int k = 0; k < n; k++) begin
      valid_data = 1;
      data_output = first + 16'(k);
      tick();
    end
    valid_data = 0;
  endtask
  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s u%0d we", tag, i), 32'(mem_we[i]), 0);
      check($sformatf("%s u%0d addr", tag, i), 32'(mem_addr[i]), 0);
      check($sformatf("%s u%0d wdata", tag, i), 32'(mem_wdata[i]), 0);
      check($sformatf("%s u%0d tiles", tag, i), 32'(tile_count[i]), 0);
      check($sformatf("%s u%0d err", tag, i), 32'(burst_err[i]), 0);
      check($sformatf("%s u%0d done", tag, i), 32'(done[i]), 0);
    end
  endtask
  initial begin
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    burst(3, 16'h0011);
    pulse_start(16'h0100);
    burst(8, 16'h0001);
    idle(2);
    pulse_start(16'h0100);
    valid_data = 1; data_output = 16'h8001; tick();
    data_output = 16'h7FFF; tick();
    data_output = 16'h0000; tick();
    data_output = 16'hFFFF; tick();
    idle(2);
    pulse_start(16'h0100);
    burst(5, 16'h0A00);
    idle(1);
    burst(8, 16'h0B00);
    idle(2);
    pulse_start(16'h0100);
    burst(16, 16'h0C00);
    burst(2, 16'h0D00);
    idle(2);
    pulse_start(16'h0100);
    burst(3, 16'h0E00);
    valid_data = 1; base_addr = 16'h0200; start = 1; data_output = 16'h0EEE; tick();
    start = 0;
    burst(8, 16'h0F00);
    idle(1);
    pulse_start(16'h0300);
    burst(4, 16'h1000);
    #2;
    rst_n = 0;
    #1;
    check_zero("async");
    model_reset();
    tick();
    rst_n = 1;
    burst(4, 16'h1100);
    idle(1);
    pulse_start(16'hFFFC);
    burst(8, 16'h1200);
    idle(2);
    for (int c = 0; c < 3000; c++) begin
      start = $urandom_range(99) < 2;
      base_addr = $urandom_range(3) == 0 ? 16'hFFF0 + 16'($urandom_range(15)) : 16'($urandom);
      valid_data = $urandom_range(9) < 8;
      data_output = 16'($urandom);
      tick();
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
